// File: rtl/spu_issue.sv
// spu_issue: dual-issue stage ahead of the SPU even/odd pipes.
//
// Takes one pre-decoded instruction pair per handshake and holds it in a
// two-slot buffer (slot 0 older, slot 1 younger). RAW and WAW hazards are
// resolved against a per-register result-latency scoreboard. Up to one
// instruction per pipe issues each cycle, always in program order.
// Every pipe-facing output is registered.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         pair handshake
//   in_pc                       PC of slot 0 (slot 1 is at in_pc + 4)
//   in_pipeN, in_latN           target pipe (0 even, 1 odd); result latency (0 = no write)
//   in_rtN/raN/rbN/rcN          register fields
//   in_useN                     source-used flags {ra, rb, rc}
//   in_uopN, in_immN            opcode payload and raw immediate (passed through)
//   flush                       branch redirect: drop the buffered pair
//   ep_* / op_*                 registered issue to the even / odd pipe
//   op_pc                       PC of the odd-pipe instruction

// Hazard check for one buffered slot. The check reads the scoreboard
// after this cycle's decrement. A producer issued at edge t with latency L
// therefore releases its consumer at edge t+L.
module spu_issue_chk #(
  parameter int LAT_WD  = 3,
  parameter int ADDR_WD = 7,
  parameter int NREG    = 128
) (
  input  logic [NREG-1:0][LAT_WD-1:0] sb_eff,
  input  logic [ADDR_WD-1:0]          ra,
  input  logic [ADDR_WD-1:0]          rb,
  input  logic [ADDR_WD-1:0]          rc,
  input  logic [ADDR_WD-1:0]          rt,
  input  logic [2:0]                  srcs,
  input  logic [LAT_WD-1:0]           lat,
  output logic                        ok
);
  logic src_ok, waw_ok;

  assign src_ok = (!srcs[2] || sb_eff[ra] == '0) &&
                  (!srcs[1] || sb_eff[rb] == '0) &&
                  (!srcs[0] || sb_eff[rc] == '0);
  // A new writer may not finish ahead of an older in-flight write to rt.
  assign waw_ok = (lat == '0) || (sb_eff[rt] <= lat);
  assign ok     = src_ok && waw_ok;
endmodule

module spu_issue #(
  parameter int LAT_WD  = 3,
  parameter int ADDR_WD = 7,
  parameter int UOP_WD  = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic                in_pipe0,
  input  logic                in_pipe1,
  input  logic [LAT_WD-1:0]   in_lat0,
  input  logic [LAT_WD-1:0]   in_lat1,
  input  logic [ADDR_WD-1:0]  in_rt0,
  input  logic [ADDR_WD-1:0]  in_rt1,
  input  logic [ADDR_WD-1:0]  in_ra0,
  input  logic [ADDR_WD-1:0]  in_ra1,
  input  logic [ADDR_WD-1:0]  in_rb0,
  input  logic [ADDR_WD-1:0]  in_rb1,
  input  logic [ADDR_WD-1:0]  in_rc0,
  input  logic [ADDR_WD-1:0]  in_rc1,
  input  logic [2:0]          in_use0,
  input  logic [2:0]          in_use1,
  input  logic [UOP_WD-1:0]   in_uop0,
  input  logic [UOP_WD-1:0]   in_uop1,
  input  logic [17:0]         in_imm0,
  input  logic [17:0]         in_imm1,
  input  logic                flush,
  output logic                ep_valid,
  output logic [UOP_WD-1:0]   ep_uop,
  output logic [ADDR_WD-1:0]  ep_ra,
  output logic [ADDR_WD-1:0]  ep_rb,
  output logic [ADDR_WD-1:0]  ep_rc,
  output logic [ADDR_WD-1:0]  ep_rt,
  output logic [17:0]         ep_imm,
  output logic                op_valid,
  output logic [UOP_WD-1:0]   op_uop,
  output logic [ADDR_WD-1:0]  op_ra,
  output logic [ADDR_WD-1:0]  op_rb,
  output logic [ADDR_WD-1:0]  op_rc,
  output logic [ADDR_WD-1:0]  op_rt,
  output logic [17:0]         op_imm,
  output logic [31:0]         op_pc
);
  localparam int NREG = 1 << ADDR_WD;

  typedef struct packed {
    logic               pipe;
    logic [LAT_WD-1:0]  lat;
    logic [ADDR_WD-1:0] rt;
    logic [ADDR_WD-1:0] ra;
    logic [ADDR_WD-1:0] rb;
    logic [ADDR_WD-1:0] rc;
    logic [2:0]         srcs;
    logic [UOP_WD-1:0]  uop;
    logic [17:0]        imm;
  } ins_t;

  typedef struct packed {
    logic               vld;
    logic [UOP_WD-1:0]  uop;
    logic [ADDR_WD-1:0] ra;
    logic [ADDR_WD-1:0] rb;
    logic [ADDR_WD-1:0] rc;
    logic [ADDR_WD-1:0] rt;
    logic [17:0]        imm;
  } out_t;

  function automatic out_t to_out(input ins_t i);
    out_t o;
    o.vld = 1'b1;
    o.uop = i.uop;
    o.ra  = i.ra;
    o.rb  = i.rb;
    o.rc  = i.rc;
    o.rt  = i.rt;
    o.imm = i.imm;
    return o;
  endfunction

  ins_t [1:0]                  slot_q, in_ins;
  logic [1:0]                  pend_q;
  logic [31:0]                 pc_q;
  logic [NREG-1:0][LAT_WD-1:0] sb_q, sb_eff, sb_n;
  out_t                        ep_q, op_q, ep_n, op_n;
  logic [31:0]                 op_pc_q, op_pc_n, pc_a;

  logic       a_sel, a_vld, b_vld, a_wr, b_wr, b_dep, iss_a, iss_b, acc;
  logic [1:0] ok, iss;
  ins_t       ia, ib;

  assign in_ins[0] = '{pipe: in_pipe0, lat: in_lat0, rt: in_rt0, ra: in_ra0,
                       rb: in_rb0, rc: in_rc0, srcs: in_use0, uop: in_uop0,
                       imm: in_imm0};
  assign in_ins[1] = '{pipe: in_pipe1, lat: in_lat1, rt: in_rt1, ra: in_ra1,
                       rb: in_rb1, rc: in_rc1, srcs: in_use1, uop: in_uop1,
                       imm: in_imm1};

  // Scoreboard as it will stand after this cycle's decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++)
      sb_eff[r] = (sb_q[r] != '0) ? sb_q[r] - LAT_WD'(1) : '0;
  end

  for (genvar i = 0; i < 2; i++) begin : g_chk
    spu_issue_chk #(.LAT_WD(LAT_WD), .ADDR_WD(ADDR_WD), .NREG(NREG)) u_chk (
      .sb_eff (sb_eff),
      .ra     (slot_q[i].ra),
      .rb     (slot_q[i].rb),
      .rc     (slot_q[i].rc),
      .rt     (slot_q[i].rt),
      .srcs   (slot_q[i].srcs),
      .lat    (slot_q[i].lat),
      .ok     (ok[i])
    );
  end

  // A is the oldest pending slot. B exists only while both slots are
  // pending, and it can then only be slot 1.
  always_comb begin
    a_sel = !pend_q[0];
    ia    = slot_q[a_sel];
    ib    = slot_q[1];
    a_vld = |pend_q;
    b_vld = &pend_q;
    a_wr  = ia.lat != '0;
    b_wr  = ib.lat != '0;
    // A's result is not yet in the scoreboard, so intra-pair RAW/WAW
    // hazards are caught by comparing register fields directly.
    b_dep = (ib.srcs[2] && ib.ra == ia.rt) ||
            (ib.srcs[1] && ib.rb == ia.rt) ||
            (ib.srcs[0] && ib.rc == ia.rt);
    iss_a = !flush && a_vld && ok[a_sel];
    iss_b = iss_a && b_vld && (ib.pipe != ia.pipe) && ok[1] &&
            !(a_wr && b_dep) && !(a_wr && b_wr && ib.rt == ia.rt);
    iss[0] = iss_a && !a_sel;
    iss[1] = (iss_a && a_sel) || iss_b;
  end

  // Accept a new pair only when the buffer drains completely this cycle.
  assign in_ready = !rst && !flush && ((pend_q & ~iss) == 2'b00);
  assign acc      = in_valid && in_ready;

  // A load from an issuing writer overrides the decrement of that entry.
  // A and B never target the same rt when both write.
  always_comb begin
    sb_n = sb_eff;
    if (iss_a && a_wr) sb_n[ia.rt] = ia.lat;
    if (iss_b && b_wr) sb_n[ib.rt] = ib.lat;
  end

  always_comb begin
    ep_n    = '0;
    op_n    = '0;
    op_pc_n = '0;
    pc_a    = a_sel ? pc_q + 32'd4 : pc_q;
    if (iss_a) begin
      if (ia.pipe) begin
        op_n    = to_out(ia);
        op_pc_n = pc_a;
      end else begin
        ep_n = to_out(ia);
      end
    end
    if (iss_b) begin
      if (ib.pipe) begin
        op_n    = to_out(ib);
        op_pc_n = pc_q + 32'd4;
      end else begin
        ep_n = to_out(ib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      slot_q  <= '0;
      pc_q    <= '0;
      sb_q    <= '0;
      ep_q    <= '0;
      op_q    <= '0;
      op_pc_q <= '0;
    end else begin
      sb_q    <= sb_n;
      ep_q    <= ep_n;
      op_q    <= op_n;
      op_pc_q <= op_pc_n;
      if (flush) begin
        pend_q <= '0;
      end else if (acc) begin
        pend_q <= 2'b11;
        slot_q <= in_ins;
        pc_q   <= in_pc;
      end else begin
        pend_q <= pend_q & ~iss;
      end
    end
  end

  assign ep_valid = ep_q.vld;
  assign ep_uop   = ep_q.uop;
  assign ep_ra    = ep_q.ra;
  assign ep_rb    = ep_q.rb;
  assign ep_rc    = ep_q.rc;
  assign ep_rt    = ep_q.rt;
  assign ep_imm   = ep_q.imm;
  assign op_valid = op_q.vld;
  assign op_uop   = op_q.uop;
  assign op_ra    = op_q.ra;
  assign op_rb    = op_q.rb;
  assign op_rc    = op_q.rc;
  assign op_rt    = op_q.rt;
  assign op_imm   = op_q.imm;
  assign op_pc    = op_pc_q;
endmodule

// File: tb/tb_spu_issue.sv
// Directed bench for spu_issue: one task per scenario with hand-computed
// expectations. Inputs change #1 after a rising edge; outputs are sampled
// at the same point.
module tb_spu_issue;
  localparam int LAT_WD = 3, ADDR_WD = 7, UOP_WD = 11;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0;
  logic in_ready;
  logic [31:0] in_pc = '0;
  logic in_pipe0 = 0, in_pipe1 = 0;
  logic [LAT_WD-1:0] in_lat0 = '0, in_lat1 = '0;
  logic [ADDR_WD-1:0] in_rt0 = '0, in_rt1 = '0, in_ra0 = '0, in_ra1 = '0;
  logic [ADDR_WD-1:0] in_rb0 = '0, in_rb1 = '0, in_rc0 = '0, in_rc1 = '0;
  logic [2:0] in_use0 = '0, in_use1 = '0;
  logic [UOP_WD-1:0] in_uop0 = '0, in_uop1 = '0;
  logic [17:0] in_imm0 = '0, in_imm1 = '0;
  logic ep_valid, op_valid;
  logic [UOP_WD-1:0] ep_uop, op_uop;
  logic [ADDR_WD-1:0] ep_ra, ep_rb, ep_rc, ep_rt, op_ra, op_rb, op_rc, op_rt;
  logic [17:0] ep_imm, op_imm;
  logic [31:0] op_pc;

  int checks = 0, errors = 0;

  spu_issue #(.LAT_WD(LAT_WD), .ADDR_WD(ADDR_WD), .UOP_WD(UOP_WD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pipe0(in_pipe0), .in_pipe1(in_pipe1),
    .in_lat0(in_lat0), .in_lat1(in_lat1), .in_rt0(in_rt0), .in_rt1(in_rt1),
    .in_ra0(in_ra0), .in_ra1(in_ra1), .in_rb0(in_rb0), .in_rb1(in_rb1),
    .in_rc0(in_rc0), .in_rc1(in_rc1), .in_use0(in_use0), .in_use1(in_use1),
    .in_uop0(in_uop0), .in_uop1(in_uop1), .in_imm0(in_imm0), .in_imm1(in_imm1),
    .flush(flush),
    .ep_valid(ep_valid), .ep_uop(ep_uop), .ep_ra(ep_ra), .ep_rb(ep_rb),
    .ep_rc(ep_rc), .ep_rt(ep_rt), .ep_imm(ep_imm),
    .op_valid(op_valid), .op_uop(op_uop), .op_ra(op_ra), .op_rb(op_rb),
    .op_rc(op_rc), .op_rt(op_rt), .op_imm(op_imm), .op_pc(op_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic pipe, input logic [2:0] lat,
                          input logic [6:0] rt, input logic [6:0] ra,
                          input logic [6:0] rb, input logic [6:0] rc,
                          input logic [2:0] srcs, input logic [10:0] uop,
                          input logic [17:0] imm);
    if (s == 0) begin
      in_pipe0 = pipe; in_lat0 = lat; in_rt0 = rt; in_ra0 = ra; in_rb0 = rb;
      in_rc0 = rc; in_use0 = srcs; in_uop0 = uop; in_imm0 = imm;
    end else begin
      in_pipe1 = pipe; in_lat1 = lat; in_rt1 = rt; in_ra1 = ra; in_rb1 = rb;
      in_rc1 = rc; in_use1 = srcs; in_uop1 = uop; in_imm1 = imm;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) tick;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; flush = 0;
    tick; tick;
    checks++;
    if ({ep_valid, op_valid, in_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_valids got %b exp 000", {ep_valid, op_valid, in_ready});
    end
    checks++;
    if ({ep_uop, ep_rt, ep_imm, op_uop, op_rt, op_imm, op_pc} !== '0) begin
      errors++; $display("FAIL reset_fields got ep_uop %h op_uop %h op_pc %h exp 0", ep_uop, op_uop, op_pc);
    end
    rst = 0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", in_ready);
    end
    tick;
  endtask

  task automatic test_dual;
    set_slot(0, 0, 2, 5, 1, 2, 3, 3'b000, 11'h015, 18'h00123);
    set_slot(1, 1, 6, 6, 4, 0, 0, 3'b000, 11'h02a, 18'h3ff00);
    in_pc = 32'h1000; in_valid = 1;
    tick;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL dual_ready_k got %b exp 1", in_ready);
    end
    set_slot(0, 0, 1, 8, 0, 0, 0, 3'b000, 11'h033, 18'h00001);
    set_slot(1, 1, 1, 9, 0, 0, 0, 3'b000, 11'h044, 18'h00002);
    in_pc = 32'h2000;
    tick;
    checks++;
    if ({ep_valid, ep_uop, ep_rt, ep_ra, ep_rb, ep_rc, ep_imm} !==
        {1'b1, 11'h015, 7'd5, 7'd1, 7'd2, 7'd3, 18'h00123}) begin
      errors++; $display("FAIL dual_ep1 got v%b uop %h rt %0d imm %h exp v1 uop 015 rt 5 imm 00123", ep_valid, ep_uop, ep_rt, ep_imm);
    end
    checks++;
    if ({op_valid, op_uop, op_rt, op_ra, op_imm, op_pc} !==
        {1'b1, 11'h02a, 7'd6, 7'd4, 18'h3ff00, 32'h1004}) begin
      errors++; $display("FAIL dual_op1 got v%b uop %h rt %0d pc %h exp v1 uop 02a rt 6 pc 1004", op_valid, op_uop, op_rt, op_pc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL dual_ready_k1 got %b exp 1", in_ready);
    end
    in_valid = 0;
    tick;
    checks++;
    if ({ep_valid, ep_uop, ep_rt, op_valid, op_uop, op_pc} !==
        {1'b1, 11'h033, 7'd8, 1'b1, 11'h044, 32'h2004}) begin
      errors++; $display("FAIL dual_pair2 got ep v%b %h op v%b %h pc %h exp ep v1 033 op v1 044 pc 2004", ep_valid, ep_uop, op_valid, op_uop, op_pc);
    end
    tick;
    checks++;
    if ({ep_valid, op_valid} !== 2'b00) begin
      errors++; $display("FAIL dual_drain got %b exp 00", {ep_valid, op_valid});
    end
    idle(8);
  endtask

  task automatic test_same_pipe;
    set_slot(0, 0, 1, 20, 0, 0, 0, 3'b000, 11'h051, 18'h0);
    set_slot(1, 0, 1, 21, 0, 0, 0, 3'b000, 11'h052, 18'h0);
    in_pc = 32'h3000; in_valid = 1;
    tick;
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL same_ready got %b exp 0", in_ready);
    end
    tick;
    checks++;
    if ({ep_valid, ep_uop, op_valid} !== {1'b1, 11'h051, 1'b0}) begin
      errors++; $display("FAIL same_k1 got ep v%b %h op v%b exp ep v1 051 op v0", ep_valid, ep_uop, op_valid);
    end
    tick;
    checks++;
    if ({ep_valid, ep_uop, ep_rt, op_valid} !== {1'b1, 11'h052, 7'd21, 1'b0}) begin
      errors++; $display("FAIL same_k2 got ep v%b %h rt %0d op v%b exp ep v1 052 rt 21 op v0", ep_valid, ep_uop, ep_rt, op_valid);
    end
    idle(6);
  endtask

  task automatic test_raw_latency;
    set_slot(0, 1, 6, 10, 0, 0, 0, 3'b000, 11'h061, 18'h0);
    set_slot(1, 0, 0, 0, 0, 0, 0, 3'b000, 11'h062, 18'h0);
    in_pc = 32'h4000; in_valid = 1;
    tick;
    set_slot(0, 0, 0, 0, 10, 0, 0, 3'b100, 11'h063, 18'h0);
    set_slot(1, 1, 0, 0, 0, 0, 0, 3'b000, 11'h064, 18'h0);
    in_pc = 32'h4100;
    tick;
    in_valid = 0;
    checks++;
    if ({op_valid, op_uop, ep_valid, ep_uop} !== {1'b1, 11'h061, 1'b1, 11'h062}) begin
      errors++; $display("FAIL raw_prod got op v%b %h ep v%b %h exp op v1 061 ep v1 062", op_valid, op_uop, ep_valid, ep_uop);
    end
    for (int i = 2; i <= 6; i++) begin
      tick;
      checks++;
      if ({ep_valid, op_valid} !== 2'b00) begin
        errors++; $display("FAIL raw_stall cycle %0d got %b exp 00", i, {ep_valid, op_valid});
      end
    end
    tick;
    checks++;
    if ({ep_valid, ep_uop, op_valid, op_uop, op_pc} !==
        {1'b1, 11'h063, 1'b1, 11'h064, 32'h4104}) begin
      errors++; $display("FAIL raw_cons got ep v%b %h op v%b %h pc %h exp ep v1 063 op v1 064 pc 4104", ep_valid, ep_uop, op_valid, op_uop, op_pc);
    end
    idle(4);
  endtask

  task automatic test_intra_raw;
    set_slot(0, 0, 2, 3, 0, 0, 0, 3'b000, 11'h071, 18'h0);
    set_slot(1, 1, 0, 0, 0, 3, 0, 3'b010, 11'h072, 18'h0);
    in_pc = 32'h5000; in_valid = 1;
    tick;
    in_valid = 0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL intra_ready_k got %b exp 0", in_ready);
    end
    tick;
    checks++;
    if ({ep_valid, ep_uop, op_valid} !== {1'b1, 11'h071, 1'b0}) begin
      errors++; $display("FAIL intra_k1 got ep v%b %h op v%b exp ep v1 071 op v0", ep_valid, ep_uop, op_valid);
    end
    tick;
    checks++;
    if ({ep_valid, op_valid, in_ready} !== 3'b001) begin
      errors++; $display("FAIL intra_k2 got ep/op/ready %b exp 001", {ep_valid, op_valid, in_ready});
    end
    tick;
    checks++;
    if ({op_valid, op_uop, op_rb, op_pc, ep_valid} !== {1'b1, 11'h072, 7'd3, 32'h5004, 1'b0}) begin
      errors++; $display("FAIL intra_k3 got op v%b %h rb %0d pc %h ep v%b exp op v1 072 rb 3 pc 5004 ep v0", op_valid, op_uop, op_rb, op_pc, ep_valid);
    end
    idle(4);
  endtask

  task automatic test_waw;
    set_slot(0, 1, 7, 7, 0, 0, 0, 3'b000, 11'h081, 18'h0);
    set_slot(1, 0, 2, 7, 0, 0, 0, 3'b000, 11'h082, 18'h0);
    in_pc = 32'h6000; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    checks++;
    if ({op_valid, op_uop, ep_valid} !== {1'b1, 11'h081, 1'b0}) begin
      errors++; $display("FAIL waw_first got op v%b %h ep v%b exp op v1 081 ep v0", op_valid, op_uop, ep_valid);
    end
    for (int i = 2; i <= 5; i++) begin
      tick;
      checks++;
      if (ep_valid !== 1'b0) begin
        errors++; $display("FAIL waw_stall cycle %0d got %b exp 0", i, ep_valid);
      end
    end
    tick;
    checks++;
    if ({ep_valid, ep_uop, ep_rt} !== {1'b1, 11'h082, 7'd7}) begin
      errors++; $display("FAIL waw_second got v%b %h rt %0d exp v1 082 rt 7", ep_valid, ep_uop, ep_rt);
    end
    idle(6);
  endtask

  task automatic test_flush;
    set_slot(0, 0, 3, 12, 0, 0, 0, 3'b000, 11'h091, 18'h0);
    set_slot(1, 1, 0, 0, 12, 0, 0, 3'b100, 11'h092, 18'h0);
    in_pc = 32'h7000; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    checks++;
    if ({ep_valid, ep_uop, op_valid} !== {1'b1, 11'h091, 1'b0}) begin
      errors++; $display("FAIL flush_k1 got ep v%b %h op v%b exp ep v1 091 op v0", ep_valid, ep_uop, op_valid);
    end
    flush = 1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready_hi got %b exp 0", in_ready);
    end
    tick;
    flush = 0; #1;
    checks++;
    if ({ep_valid, op_valid, in_ready} !== 3'b001) begin
      errors++; $display("FAIL flush_after got ep/op/ready %b exp 001", {ep_valid, op_valid, in_ready});
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (op_valid !== 1'b0) begin
        errors++; $display("FAIL flush_ghost cycle %0d got %b exp 0", i, op_valid);
      end
    end
    // flush in the same cycle an independent pair would issue
    set_slot(0, 0, 0, 0, 0, 0, 0, 3'b000, 11'h0a1, 18'h0);
    set_slot(1, 1, 0, 0, 0, 0, 0, 3'b000, 11'h0a2, 18'h0);
    in_pc = 32'h7100; in_valid = 1;
    tick;
    in_valid = 0; flush = 1;
    tick;
    flush = 0;
    checks++;
    if ({ep_valid, op_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_wins got %b exp 00", {ep_valid, op_valid});
    end
    tick;
    checks++;
    if ({ep_valid, op_valid} !== 2'b00) begin
      errors++; $display("FAIL flush_cleared got %b exp 00", {ep_valid, op_valid});
    end
    idle(4);
  endtask

  task automatic test_reset_mid_stall;
    set_slot(0, 1, 7, 15, 0, 0, 0, 3'b000, 11'h0b1, 18'h0);
    set_slot(1, 0, 0, 0, 15, 0, 0, 3'b100, 11'h0b2, 18'h0);
    in_pc = 32'h8000; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    checks++;
    if ({op_valid, op_uop, op_pc} !== {1'b1, 11'h0b1, 32'h8000}) begin
      errors++; $display("FAIL rst_prod got op v%b %h pc %h exp v1 0b1 8000", op_valid, op_uop, op_pc);
    end
    rst = 1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b exp 0", in_ready);
    end
    tick;
    rst = 0;
    checks++;
    if ({ep_valid, op_valid, ep_uop, op_uop, op_rt, op_pc} !== '0) begin
      errors++; $display("FAIL rst_outputs got ep v%b op v%b op_uop %h op_pc %h exp 0", ep_valid, op_valid, op_uop, op_pc);
    end
    tick;
    checks++;
    if ({ep_valid, op_valid} !== 2'b00) begin
      errors++; $display("FAIL rst_no_ghost got %b exp 00", {ep_valid, op_valid});
    end
    // sb[15] must read 0 now, so a reader of r15 issues without stalling
    set_slot(0, 0, 0, 0, 15, 0, 0, 3'b100, 11'h0b3, 18'h0);
    set_slot(1, 1, 0, 0, 0, 0, 0, 3'b000, 11'h0b4, 18'h0);
    in_pc = 32'h8100; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    checks++;
    if ({ep_valid, ep_uop, op_valid, op_uop, op_pc} !==
        {1'b1, 11'h0b3, 1'b1, 11'h0b4, 32'h8104}) begin
      errors++; $display("FAIL rst_sb_clear got ep v%b %h op v%b %h pc %h exp ep v1 0b3 op v1 0b4 pc 8104", ep_valid, ep_uop, op_valid, op_uop, op_pc);
    end
    idle(2);
  endtask

  initial begin
    test_reset;
    test_dual;
    test_same_pipe;
    test_raw_latency;
    test_intra_raw;
    test_waw;
    test_flush;
    test_reset_mid_stall;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
